// File: rtl/sw_align_sequencer.sv
// Job-level controller for the Smith-Waterman systolic scoring array.
// Takes one alignment job at a time, streams its target bases into the array
// as one unbroken enable window, waits for the selected PE to report, and
// hands the score back over a valid/ready port. A fixed idle gap with the
// array enable low separates jobs so the PE chain drains before the next
// sequence starts.
module sw_align_sequencer #(
  parameter int SCORE_WIDTH = 12,
  parameter int LENGTH      = 128,
  parameter int LOG_LENGTH  = 8,
  parameter int TLEN_WIDTH  = 16,
  parameter int DRAIN_MAX   = 260,
  parameter int GAP_CYCLES  = 4,
  parameter logic [SCORE_WIDTH-1:0] ZERO = {1'b1, {(SCORE_WIDTH-1){1'b0}}}
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    job_valid,
  output logic                    job_ready,
  input  logic [2*LENGTH-1:0]     job_query,
  input  logic [LOG_LENGTH-1:0]   job_qlen,
  input  logic [TLEN_WIDTH-1:0]   job_tlen,
  input  logic                    base_valid,
  output logic                    base_ready,
  input  logic [1:0]              base_data,
  output logic                    arr_en,
  output logic [1:0]              arr_data,
  output logic [2*LENGTH-1:0]     arr_query,
  output logic [LOG_LENGTH-1:0]   arr_sel,
  input  logic                    arr_vld,
  input  logic [SCORE_WIDTH-1:0]  arr_result,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic [SCORE_WIDTH-1:0]  res_score,
  output logic                    res_err,
  output logic                    busy
);

  localparam int DCNT_W = $clog2(DRAIN_MAX + 1);
  localparam int GCNT_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int QLEN_W = LOG_LENGTH + 1;

  localparam logic [DCNT_W-1:0]     DRAIN_LIMIT = DCNT_W'(DRAIN_MAX);
  localparam logic [GCNT_W-1:0]     GAP_LAST    = GCNT_W'(GAP_CYCLES - 1);
  localparam logic [QLEN_W-1:0]     QLEN_MAX    = QLEN_W'(LENGTH);
  localparam logic [TLEN_WIDTH-1:0] TLEN_ONE    = TLEN_WIDTH'(1);
  localparam logic [DCNT_W-1:0]     DCNT_ONE    = DCNT_W'(1);
  localparam logic [GCNT_W-1:0]     GCNT_ONE    = GCNT_W'(1);

  typedef enum logic [2:0] {
    IDLE,
    STREAM,
    DRAIN,
    RESULT,
    GAP
  } state_t;

  state_t                  state_q;
  logic                    jobReady_q;
  logic                    baseReady_q;
  logic                    arrEn_q;
  logic [1:0]              arrData_q;
  logic [2*LENGTH-1:0]     arrQuery_q;
  logic [LOG_LENGTH-1:0]   arrSel_q;
  logic                    resValid_q;
  logic [SCORE_WIDTH-1:0]  resScore_q;
  logic                    resErr_q;
  logic                    busy_q;
  logic [TLEN_WIDTH-1:0]   tlen_q;
  logic [TLEN_WIDTH-1:0]   bcnt_q;
  logic [DCNT_W-1:0]       dcnt_q;
  logic [GCNT_W-1:0]       gcnt_q;
  // Set when the job died from base underflow: its gap is served before the
  // result is presented rather than after.
  logic                    ufPath_q;

  logic [TLEN_WIDTH-1:0]   bcnt_d;
  logic [DCNT_W-1:0]       dcnt_d;
  logic                    jobIllegal;

  // Next counter values and the job legality check used at acceptance.
  always_comb begin
    bcnt_d     = bcnt_q + TLEN_ONE;
    dcnt_d     = (dcnt_q == DRAIN_LIMIT) ? dcnt_q : (dcnt_q + DCNT_ONE);
    jobIllegal = (job_qlen == '0) || ({1'b0, job_qlen} > QLEN_MAX) || (job_tlen == '0);
  end

  // Job sequencing state machine; every output is a register written here.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      jobReady_q  <= 1'b1;
      baseReady_q <= 1'b0;
      arrEn_q     <= 1'b0;
      arrData_q   <= '0;
      arrQuery_q  <= '0;
      arrSel_q    <= '0;
      resValid_q  <= 1'b0;
      resScore_q  <= ZERO;
      resErr_q    <= 1'b0;
      busy_q      <= 1'b0;
      tlen_q      <= '0;
      bcnt_q      <= '0;
      dcnt_q      <= '0;
      gcnt_q      <= '0;
      ufPath_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (job_valid && jobReady_q) begin
            arrQuery_q <= job_query;
            arrSel_q   <= job_qlen;
            tlen_q     <= job_tlen;
            bcnt_q     <= '0;
            dcnt_q     <= '0;
            gcnt_q     <= '0;
            ufPath_q   <= 1'b0;
            jobReady_q <= 1'b0;
            busy_q     <= 1'b1;
            if (jobIllegal) begin
              resScore_q <= ZERO;
              resErr_q   <= 1'b1;
              state_q    <= RESULT;
            end else begin
              baseReady_q <= 1'b1;
              state_q     <= STREAM;
            end
          end
        end

        STREAM: begin
          if (base_valid) begin
            arrEn_q   <= 1'b1;
            arrData_q <= base_data;
            bcnt_q    <= bcnt_d;
            if (bcnt_d == tlen_q) begin
              baseReady_q <= 1'b0;
              state_q     <= DRAIN;
            end
          end else begin
            // A hole in the base stream would split the array's sequence, so
            // the job is abandoned and the array is let to drain first.
            arrEn_q     <= 1'b0;
            baseReady_q <= 1'b0;
            resScore_q  <= ZERO;
            resErr_q    <= 1'b1;
            ufPath_q    <= 1'b1;
            gcnt_q      <= '0;
            state_q     <= GAP;
          end
        end

        DRAIN: begin
          arrEn_q <= 1'b0;
          dcnt_q  <= dcnt_d;
          if (arr_vld) begin
            resScore_q <= arr_result;
            resErr_q   <= 1'b0;
            state_q    <= RESULT;
          end else if (dcnt_d == DRAIN_LIMIT) begin
            resScore_q <= ZERO;
            resErr_q   <= 1'b1;
            state_q    <= RESULT;
          end
        end

        RESULT: begin
          if (!resValid_q) begin
            resValid_q <= 1'b1;
          end else if (res_ready) begin
            resValid_q <= 1'b0;
            if (ufPath_q) begin
              jobReady_q <= 1'b1;
              busy_q     <= 1'b0;
              state_q    <= IDLE;
            end else begin
              gcnt_q  <= '0;
              state_q <= GAP;
            end
          end
        end

        GAP: begin
          arrEn_q <= 1'b0;
          if (gcnt_q == GAP_LAST) begin
            if (ufPath_q) begin
              state_q <= RESULT;
            end else begin
              jobReady_q <= 1'b1;
              busy_q     <= 1'b0;
              state_q    <= IDLE;
            end
          end else begin
            gcnt_q <= gcnt_q + GCNT_ONE;
          end
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign job_ready  = jobReady_q;
  assign base_ready = baseReady_q;
  assign arr_en     = arrEn_q;
  assign arr_data   = arrData_q;
  assign arr_query  = arrQuery_q;
  assign arr_sel    = arrSel_q;
  assign res_valid  = resValid_q;
  assign res_score  = resScore_q;
  assign res_err    = resErr_q;
  assign busy       = busy_q;

endmodule
